// File: rtl/ysyx_24090018_idu_stage_pkg.sv
// ============================================================================
// Module : ysyx_24090018_idu_stage_pkg
// Desc   : Shared defines for the decode stage: opcodes, ALU ops, imm formats.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ysyx_24090018_idu_stage_pkg;

    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] C_INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5
    } imm_fmt_e;

    // alt selects SUB / SRA (funct7[5])
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24090018_immgen.sv
// ============================================================================
// Module : ysyx_24090018_immgen
// Desc   : Combinational RISC-V immediate generator (I/S/B/U/J/shamt).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ysyx_24090018_immgen
    import ysyx_24090018_idu_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           inst,
    input  logic [2:0]            fmt,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (fmt)
            IMM_I:     w_imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:     w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:     w_imm32 = {inst[31:12], 12'b0};
            IMM_J:     w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_SHAMT: w_imm32 = {27'b0, inst[24:20]};
            default:   w_imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/ysyx_24090018_idu_stage.sv
// ============================================================================
// Module : ysyx_24090018_idu_stage
// Desc   : Decode stage with one-deep output register; optional RV32E register
//          check enabled by YSYX_24090018_RV32E_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ysyx_24090018_idu_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic [DATA_WIDTH-1:0] inst_addr_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr1_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr2_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata1_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata2_i,
    input  logic                  flush_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] op1_o,
    output logic [DATA_WIDTH-1:0] op2_o,
    output logic [DATA_WIDTH-1:0] op1_jump_o,
    output logic [DATA_WIDTH-1:0] op2_jump_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [DATA_WIDTH-1:0] inst_addr_o,
    output logic [3:0]            alu_op_o,
    output logic [2:0]            funct3_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic                  rf_we_o,
    output logic                  jump_flag_o,
    output logic                  branch_flag_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic                  ebreak_o,
    output logic                  illegal_o
);

    import ysyx_24090018_idu_stage_pkg::*;

    localparam int C_PIPE_W = 6 * DATA_WIDTH + 4 + 3 + ADDR_WIDTH + 7;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [4:0]            w_rs1, w_rs2, w_rd;
    imm_fmt_e              w_imm_fmt;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_use_rs1, w_use_rs2, w_use_rd, w_known, w_reg_bad, w_illegal;
    logic [DATA_WIDTH-1:0] w_op1, w_op2, w_op1j, w_op2j, w_sd;
    alu_op_e               w_alu;
    logic [2:0]            w_f3;
    logic                  w_jump, w_branch, w_mre, w_mwe, w_ebreak, w_rf_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [C_PIPE_W-1:0]   w_dec;
    logic [C_PIPE_W-1:0]   r_pipe;
    logic                  r_valid;
    logic                  w_accept;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_rs1    = inst_i[19:15];
    assign w_rs2    = inst_i[24:20];
    assign w_rd     = inst_i[11:7];

    ysyx_24090018_immgen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_immgen (
        .inst (inst_i[31:7]),
        .fmt  (w_imm_fmt),
        .imm  (w_imm)
    );

    always_comb begin
        w_imm_fmt = IMM_I;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_known   = 1'b1;
        w_op1     = '0;
        w_op2     = '0;
        w_op1j    = '0;
        w_op2j    = '0;
        w_sd      = '0;
        w_alu     = ALU_ADD;
        w_f3      = '0;
        w_jump    = 1'b0;
        w_branch  = 1'b0;
        w_mre     = 1'b0;
        w_mwe     = 1'b0;
        w_ebreak  = 1'b0;
        case (w_opcode)
            C_OPC_OP_IMM: begin
                // SLLI/SRLI/SRAI carry a 5-bit shamt, not a signed immediate
                w_imm_fmt = (w_funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op1     = rf_rdata1_i;
                w_op2     = w_imm;
                w_alu     = alu_decode(w_funct3, inst_i[30] && (w_funct3 == 3'b101));
                w_f3      = w_funct3;
            end
            C_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_op1     = rf_rdata1_i;
                w_op2     = rf_rdata2_i;
                w_alu     = alu_decode(w_funct3, inst_i[30]);
                w_f3      = w_funct3;
            end
            C_OPC_LUI: begin
                w_imm_fmt = IMM_U;
                w_use_rd  = 1'b1;
                w_op1     = w_imm;
            end
            C_OPC_AUIPC: begin
                w_imm_fmt = IMM_U;
                w_use_rd  = 1'b1;
                w_op1     = w_imm;
                w_op2     = inst_addr_i;
            end
            C_OPC_JAL: begin
                w_imm_fmt = IMM_J;
                w_use_rd  = 1'b1;
                w_op1     = inst_addr_i;
                w_op2     = DATA_WIDTH'(32'd4);
                w_op1j    = inst_addr_i;
                w_op2j    = w_imm;
                w_jump    = 1'b1;
            end
            C_OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op1     = inst_addr_i;
                w_op2     = DATA_WIDTH'(32'd4);
                w_op1j    = rf_rdata1_i;
                w_op2j    = w_imm;
                w_jump    = 1'b1;
                w_f3      = w_funct3;
            end
            C_OPC_BRANCH: begin
                w_imm_fmt = IMM_B;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1     = rf_rdata1_i;
                w_op2     = rf_rdata2_i;
                w_op1j    = inst_addr_i;
                w_op2j    = w_imm;
                w_branch  = 1'b1;
                w_alu     = ALU_SUB;
                w_f3      = w_funct3;
            end
            C_OPC_LOAD: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op1     = rf_rdata1_i;
                w_op2     = w_imm;
                w_mre     = 1'b1;
                w_f3      = w_funct3;
            end
            C_OPC_STORE: begin
                w_imm_fmt = IMM_S;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1     = rf_rdata1_i;
                w_op2     = w_imm;
                w_sd      = rf_rdata2_i;
                w_mwe     = 1'b1;
                w_f3      = w_funct3;
            end
            C_OPC_SYSTEM: begin
                // Only EBREAK is implemented; other SYSTEM encodings trap as illegal
                w_ebreak  = (inst_i[31:0] == C_INST_EBREAK);
                w_known   = w_ebreak;
                w_f3      = w_funct3;
            end
            default: w_known = 1'b0;
        endcase
    end

`ifdef YSYX_24090018_RV32E_EN
    assign w_reg_bad = (w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]) || (w_use_rd && w_rd[4]);
`else
    assign w_reg_bad = 1'b0;
`endif

    assign w_illegal   = !w_known || w_reg_bad;
    assign w_rf_we     = w_use_rd && (w_rd != 5'd0);
    assign w_waddr     = w_use_rd  ? ADDR_WIDTH'(w_rd)  : '0;
    assign rf_raddr1_o = w_use_rs1 ? ADDR_WIDTH'(w_rs1) : '0;
    assign rf_raddr2_o = w_use_rs2 ? ADDR_WIDTH'(w_rs2) : '0;

    // An illegal instruction carries nothing but its illegal flag
    assign w_dec = w_illegal ? {{(C_PIPE_W-1){1'b0}}, 1'b1}
                             : {w_op1, w_op2, w_op1j, w_op2j, w_sd, inst_addr_i,
                                w_alu, w_f3, w_waddr,
                                w_rf_we, w_jump, w_branch, w_mre, w_mwe, w_ebreak, 1'b0};

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pipe  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_pipe  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pipe  <= w_dec;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign {op1_o, op2_o, op1_jump_o, op2_jump_o, store_data_o, inst_addr_o,
            alu_op_o, funct3_o, rf_waddr_o,
            rf_we_o, jump_flag_o, branch_flag_o, mem_re_o, mem_we_o, ebreak_o, illegal_o} = r_pipe;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24090018_idu_stage.sv
// ============================================================================
// Module : tb_ysyx_24090018_idu_stage
// Desc   : Self-checking bench for the decode stage (table + scoreboard).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_24090018_idu_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush_i, out_valid, out_ready;
    logic [31:0] inst_i, inst_addr_i, rf_rdata1_i, rf_rdata2_i;
    logic [4:0]  rf_raddr1_o, rf_raddr2_o, rf_waddr_o;
    logic [31:0] op1_o, op2_o, op1_jump_o, op2_jump_o, store_data_o, inst_addr_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic        rf_we_o, jump_flag_o, branch_flag_o, mem_re_o, mem_we_o, ebreak_o, illegal_o;

    ysyx_24090018_idu_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .op1_o(op1_o), .op2_o(op2_o), .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
        .store_data_o(store_data_o), .inst_addr_o(inst_addr_o),
        .alu_op_o(alu_op_o), .funct3_o(funct3_o), .rf_waddr_o(rf_waddr_o),
        .rf_we_o(rf_we_o), .jump_flag_o(jump_flag_o), .branch_flag_o(branch_flag_o),
        .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .ebreak_o(ebreak_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // flags = {we, jump, branch, mem_re, mem_we, ebreak, illegal}
    typedef struct packed {
        logic [31:0] op1, op2, op1j, op2j, sd, pc;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  waddr;
        logic [6:0]  flags;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst, pc, rd1, rd2;
        logic [4:0]  ra1, ra2;
        exp_t        x;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   sb_id[$];
    vec_t tbl[14];
    exp_t act;

    assign act = {op1_o, op2_o, op1_jump_o, op2_jump_o, store_data_o, inst_addr_o,
                  alu_op_o, funct3_o, rf_waddr_o,
                  rf_we_o, jump_flag_o, branch_flag_o, mem_re_o, mem_we_o, ebreak_o, illegal_o};

    function automatic exp_t e(input logic [31:0] op1, op2, op1j, op2j, sd, pc,
                               input logic [3:0] alu, input logic [2:0] f3,
                               input logic [4:0] wa, input logic [6:0] fl);
        return '{op1, op2, op1j, op2j, sd, pc, alu, f3, wa, fl};
    endfunction

    function automatic vec_t v(input logic [31:0] inst, pc, rd1, rd2,
                               input logic [4:0] ra1, ra2, input exp_t x);
        return '{inst, pc, rd1, rd2, ra1, ra2, x};
    endfunction

    task automatic check(input string name, input logic [255:0] a, input logic [255:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, a, x);
        end
    endtask

    task automatic drive(input vec_t t);
        inst_i      = t.inst;
        inst_addr_i = t.pc;
        rf_rdata1_i = t.rd1;
        rf_rdata2_i = t.rd2;
    endtask

    task automatic pop_check();
        exp_t x;
        int   id;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                x  = sb.pop_front();
                id = sb_id.pop_front();
                check($sformatf("vec%0d_out", id), act, x);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = v(32'hFFF10093, 32'h100, 32'd5, 32'd0, 5'd2, 5'd0,
                    e(32'd5, 32'hFFFFFFFF, 0, 0, 0, 32'h100, 4'd0, 3'd0, 5'd1, 7'b1000000));
        tbl[1]  = v(32'h008000EF, 32'h80000000, 32'd0, 32'd0, 5'd0, 5'd0,
                    e(32'h80000000, 32'd4, 32'h80000000, 32'd8, 0, 32'h80000000, 4'd0, 3'd0, 5'd1, 7'b1100000));
        tbl[2]  = v(32'h405201B3, 32'h104, 32'd10, 32'd3, 5'd4, 5'd5,
                    e(32'd10, 32'd3, 0, 0, 0, 32'h104, 4'd1, 3'd0, 5'd3, 7'b1000000));
        tbl[3]  = v(32'h4033D313, 32'h108, 32'h80000000, 32'd0, 5'd7, 5'd0,
                    e(32'h80000000, 32'd3, 0, 0, 0, 32'h108, 4'd7, 3'd5, 5'd6, 7'b1000000));
        tbl[4]  = v(32'h12345437, 32'h10C, 32'd1, 32'd2, 5'd0, 5'd0,
                    e(32'h12345000, 32'd0, 0, 0, 0, 32'h10C, 4'd0, 3'd0, 5'd8, 7'b1000000));
        tbl[5]  = v(32'hFFFFF497, 32'h1000, 32'd0, 32'd0, 5'd0, 5'd0,
                    e(32'hFFFFF000, 32'h1000, 0, 0, 0, 32'h1000, 4'd0, 3'd0, 5'd9, 7'b1000000));
        tbl[6]  = v(32'h010100E7, 32'h200, 32'h3000, 32'd0, 5'd2, 5'd0,
                    e(32'h200, 32'd4, 32'h3000, 32'd16, 0, 32'h200, 4'd0, 3'd0, 5'd1, 7'b1100000));
        tbl[7]  = v(32'hFE208CE3, 32'h400, 32'd7, 32'd7, 5'd1, 5'd2,
                    e(32'd7, 32'd7, 32'h400, 32'hFFFFFFF8, 0, 32'h400, 4'd1, 3'd0, 5'd0, 7'b0010000));
        tbl[8]  = v(32'hFFC5A503, 32'h404, 32'h2000, 32'd0, 5'd11, 5'd0,
                    e(32'h2000, 32'hFFFFFFFC, 0, 0, 0, 32'h404, 4'd0, 3'd2, 5'd10, 7'b1001000));
        tbl[9]  = v(32'h00C6AA23, 32'h408, 32'h100, 32'hDEADBEEF, 5'd13, 5'd12,
                    e(32'h100, 32'd20, 0, 0, 32'hDEADBEEF, 32'h408, 4'd0, 3'd2, 5'd0, 7'b0000100));
        tbl[10] = v(32'h00100073, 32'h40C, 32'd0, 32'd0, 5'd0, 5'd0,
                    e(0, 0, 0, 0, 0, 32'h40C, 4'd0, 3'd0, 5'd0, 7'b0000010));
        tbl[11] = v(32'hFFFFFFFF, 32'h410, 32'd1, 32'd2, 5'd0, 5'd0,
                    e(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 5'd0, 7'b0000001));
        tbl[12] = v(32'h00108013, 32'h414, 32'd9, 32'd0, 5'd1, 5'd0,
                    e(32'd9, 32'd1, 0, 0, 0, 32'h414, 4'd0, 3'd0, 5'd0, 7'b0000000));
`ifdef YSYX_24090018_RV32E_EN
        tbl[13] = v(32'h01000833, 32'h418, 32'd0, 32'h55, 5'd0, 5'd16,
                    e(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 5'd0, 7'b0000001));
`else
        tbl[13] = v(32'h01000833, 32'h418, 32'd0, 32'h55, 5'd0, 5'd16,
                    e(32'd0, 32'h55, 0, 0, 0, 32'h418, 4'd0, 3'd0, 5'd16, 7'b1000000));
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush_i = 1'b0;
        inst_i = '0; inst_addr_i = '0; rf_rdata1_i = '0; rf_rdata2_i = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_regs", act, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Back-to-back stream through the table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            pop_check();
            drive(tbl[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_raddr", i), {rf_raddr1_o, rf_raddr2_o}, {tbl[i].ra1, tbl[i].ra2});
            if (in_ready) begin
                sb.push_back(tbl[i].x);
                sb_id.push_back(i);
            end else begin
                check("stream_in_ready", in_ready, 1);
            end
        end
        for (int k = 0; k < 4 && sb.size() > 0; k++) begin
            @(negedge clk);
            pop_check();
            in_valid = 1'b0;
        end
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        check("idle_valid_clears", out_valid, 0);

        // Stall: downstream not ready for 3 cycles, then release
        out_ready = 1'b0;
        drive(tbl[0]);
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        drive(tbl[2]);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d_in_ready", k), in_ready, 0);
            check($sformatf("stall%0d_hold", k), act, tbl[0].x);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        @(negedge clk);
        check("release_valid", out_valid, 1);
        check("release_next", act, tbl[2].x);

        // Flush with a simultaneously offered instruction
        drive(tbl[0]);
        in_valid = 1'b1;
        flush_i  = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1);
        @(negedge clk);
        flush_i  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_valid", out_valid, 0);
        check("flush_rf_we", rf_we_o, 0);
        @(negedge clk);
        check("flush_dropped", out_valid, 0);

        // Reset asserted while stalled
        out_ready = 1'b0;
        drive(tbl[0]);
        in_valid = 1'b1;
        @(negedge clk);
        check("rststall_valid", out_valid, 1);
        drive(tbl[4]);
        #2;
        rst = 1'b1;
        #1;
        check("rststall_out_valid", out_valid, 0);
        check("rststall_in_ready", in_ready, 1);
        check("rststall_regs", act, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(tbl[4]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_decode", act, tbl[4].x);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_24090018_idu_stage.md
YSYX_24090018_IDU_STAGE -- requirements
Module: ysyx_24090018_idu_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: datapath, instruction and PC width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register-index width.
REQ-003 SHALL have ports clk input 1 (system clock) and rst input 1; one clock, reset asynchronous and active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: IFU handshake.
REQ-005 SHALL have ports inst_i input DATA_WIDTH and inst_addr_i input DATA_WIDTH: instruction and its PC.
REQ-006 SHALL have ports rf_raddr1_o and rf_raddr2_o output ADDR_WIDTH, plus rf_rdata1_i and rf_rdata2_i input DATA_WIDTH: combinational register-file read.
REQ-007 SHALL have port flush_i input 1: redirect kill from EXU.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: EXU handshake.
REQ-009 SHALL have registered outputs op1_o, op2_o, op1_jump_o, op2_jump_o, store_data_o and inst_addr_o, each DATA_WIDTH.
REQ-010 SHALL have registered outputs alu_op_o 4, funct3_o 3, rf_waddr_o ADDR_WIDTH, and rf_we_o, jump_flag_o, branch_flag_o, mem_re_o, mem_we_o, ebreak_o, illegal_o, each 1.

Function
REQ-011 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-012 SHALL accept an instruction when in_valid && in_ready, decode it in that cycle, and present the result with out_valid=1 on the next edge (latency 1).
REQ-013 SHALL hold every registered output stable while out_valid && !out_ready.
REQ-014 SHALL clear out_valid on the next edge when out_ready && !accept.
REQ-015 flush_i SHALL take priority over all other events: out_valid becomes 0 next edge and a simultaneously offered instruction is dropped; in_ready is unaffected.
REQ-016 Decode, by instruction class:
- I-ALU: op1=rs1 data, op2=sign-extended imm (shifts: zero-extended shamt), rf_we=1.
- R: op1=rs1, op2=rs2, alu_op from funct3/funct7[5], rf_we=1.
- LUI: op1={imm,12'b0}, op2=0.
- AUIPC: op1={imm,12'b0}, op2=pc.
- JAL: op1=pc, op2=4, jump targets pc and J-imm, jump_flag=1.
- JALR: op1=pc, op2=4, jump targets rs1 and I-imm, jump_flag=1.
- Branch: op1=rs1, op2=rs2, jump targets pc and B-imm, branch_flag=1, rf_we=0.
- Load: op1=rs1, op2=I-imm, mem_re=1, rf_we=1.
- Store: op1=rs1, op2=S-imm, store_data=rs2, mem_we=1, rf_we=0.
- EBREAK: ebreak_o=1.
REQ-017 Unused read addresses SHALL be 0.
REQ-018 An unknown opcode SHALL set illegal_o=1 with all enables 0 and all data outputs 0.
REQ-019 rf_we_o SHALL be forced to 0 when rd=0.

Reset
REQ-020 On rst, out_valid and every registered output SHALL be 0 asynchronously; in_ready SHALL be 1.
REQ-021 Reset asserted mid-stall SHALL discard the held instruction; the first post-reset accept decodes normally.

Configuration
REQ-022 With YSYX_24090018_RV32E_EN defined, any rs1/rs2/rd index >=16 used by the decoded class SHALL set illegal_o=1 with all enables 0.
REQ-023 Without YSYX_24090018_RV32E_EN, all 2^ADDR_WIDTH registers SHALL be legal.

Structure
REQ-024 Opcode constants, the ALU_OP enumeration (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS) and the immediate-format constants SHALL live in the shared Defines package.
REQ-025 Immediate generation SHALL be one combinational sub-module, ysyx_24090018_immgen; handshake and pipeline register stay in this module.

Verification
REQ-026 Bench SHALL cover: inst 0xFFF10093, rdata1=5 -> next cycle out_valid=1, op1=5, op2=0xFFFFFFFF, rf_waddr=1, rf_we=1, alu_op=ADD.
REQ-027 Bench SHALL cover: inst 0x008000EF at pc 0x80000000 -> op1=0x80000000, op2=4, op1_jump=0x80000000, op2_jump=8, jump_flag=1.
REQ-028 Bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged; on out_ready=1 the next instruction is accepted that cycle.
REQ-029 Bench SHALL cover: flush_i=1 together with an accepted instruction -> out_valid=0 next cycle, no rf_we pulse reaches EXU.
REQ-030 Bench SHALL cover: with YSYX_24090018_RV32E_EN, inst 0x01000833 -> illegal_o=1, rf_we=0; without the macro -> rf_waddr=16, rf_we=1.
REQ-031 Bench SHALL cover: rst asserted during a stall -> out_valid=0 immediately, in_ready=1.
